// File: rtl/memshare_alloc_sched_pkg.sv
// memshare_alloc_sched_pkg: scheduler FSM states, regFile field layout and L1BS timing,
// shared by the allocation scheduler and its arrival FIFO.
package memShare_config_pkg;
   localparam int L1BS_CYCLE          = 2;
   localparam int L1BSOUT_EXTRA_DELAY = 1;
   localparam int BS_LAT              = L1BS_CYCLE + L1BSOUT_EXTRA_DELAY;
   localparam int GTR_BIT             = 0;
   localparam int DELTA_LSB           = 1;
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_ISSUE,
      S_GAP
   } sched_state_e;
   function automatic int delta_msb(input int shift_w);
      return shift_w;
   endfunction
   function automatic int shift_lsb(input int shift_w);
      return shift_w + 1;
   endfunction
   function automatic int shift_msb(input int shift_w);
      return 2 * shift_w;
   endfunction
endpackage

// File: rtl/memshare_alloc_sched_rqst_fifo.sv
// memshare_rqst_fifo: synchronous arrival-pattern FIFO; exposes the head and the entry
// behind it so the scheduler can chain straight into the next read after a pop.
module memshare_rqst_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic             sys_clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             two_plus,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] head_nxt
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             wr, rd;
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction
   assign full     = cnt_q == CW'(DEPTH);
   assign empty    = cnt_q == '0;
   assign two_plus = cnt_q > CW'(1);
   assign head     = mem_q[rd_ptr_q];
   assign head_nxt = mem_q[rd_nxt];
   always_comb begin
      wr       = push && !full;
      rd       = pop && !empty;
      rd_nxt   = inc(rd_ptr_q);
      wr_ptr_d = wr ? inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd ? rd_nxt : rd_ptr_q;
      cnt_d    = cnt_q + CW'(wr) - CW'(rd);
   end
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
   always_ff @(posedge sys_clk) begin
      if (wr) mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/memshare_alloc_sched.sv
// memshare_alloc_sched: turns shared-column request patterns into one or two L1PA/L1BS
// allocation commands each. Define MEMSHARE_SCHED_PERF_CNT_EN to get the handshake counter.
module memshare_alloc_sched
   import memShare_config_pkg::*;
#(
   parameter int SHARE_GROUP_SIZE = 5,
   parameter int TRACK_DEPTH      = 4,
   parameter int PAGE_ADDR_W      = 5,
   parameter int SHIFT_W          = 3,
   parameter int BS_LAT           = memShare_config_pkg::BS_LAT
) (
   input  logic                   sys_clk,
   input  logic                   rstn,
   input  logic                   rqst_valid,
   input  logic [SHARE_GROUP_SIZE-1:0] rqst_pattern,
   output logic                   rqst_ready,
   output logic                   regfile_rd_en,
   output logic [PAGE_ADDR_W-1:0] regfile_rd_addr,
   input  logic [2*SHIFT_W:0]     regfile_rd_data,
   output logic                   alloc_valid,
   input  logic                   alloc_ready,
   output logic [SHIFT_W-1:0]     alloc_shift,
   output logic                   alloc_seq_idx,
   output logic                   alloc_last,
   output logic                   sched_idle,
   output logic [15:0]            alloc_cnt
);
   localparam int GW = (BS_LAT > 1) ? $clog2(BS_LAT + 1) : 1;
   sched_state_e state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [SHIFT_W-1:0] shift_q, shift_d, delta_q, delta_d, alloc_shift_q, alloc_shift_d;
   logic gtr_q, gtr_d, seq_q, seq_d, run_q;
   logic rd_en_q, rd_en_d, alloc_valid_q, alloc_valid_d, alloc_seq_q, alloc_seq_d, alloc_last_q, alloc_last_d;
   logic [PAGE_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [SHIFT_W:0] shift_sum;
   logic [SHIFT_W-1:0] seq1_shift;
   logic push, pop, full, empty, two_plus;
   logic [SHARE_GROUP_SIZE-1:0] head, head_nxt;
   memshare_rqst_fifo #(.WIDTH(SHARE_GROUP_SIZE), .DEPTH(TRACK_DEPTH)) u_fifo (
      .sys_clk  (sys_clk),
      .rstn     (rstn),
      .push     (push),
      .push_data(rqst_pattern),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .two_plus (two_plus),
      .head     (head),
      .head_nxt (head_nxt)
   );
   // run_q keeps ready low until the first edge after reset release
   assign rqst_ready      = run_q && !full;
   assign push            = rqst_valid && rqst_ready;
   assign sched_idle      = run_q && (state_q == S_IDLE) && empty;
   assign regfile_rd_en   = rd_en_q;
   assign regfile_rd_addr = rd_addr_q;
   assign alloc_valid     = alloc_valid_q;
   assign alloc_shift     = alloc_shift_q;
   assign alloc_seq_idx   = alloc_seq_q;
   assign alloc_last      = alloc_last_q;
   assign shift_sum       = {1'b0, shift_q} + {1'b0, delta_q};
   assign seq1_shift      = SHIFT_W'(shift_sum % (SHIFT_W + 1)'(SHARE_GROUP_SIZE));
   always_comb begin
      state_d       = state_q;
      gap_d         = gap_q;
      shift_d       = shift_q;
      delta_d       = delta_q;
      gtr_d         = gtr_q;
      seq_d         = seq_q;
      rd_en_d       = 1'b0;
      rd_addr_d     = '0;
      alloc_valid_d = alloc_valid_q;
      alloc_shift_d = alloc_shift_q;
      alloc_seq_d   = alloc_seq_q;
      alloc_last_d  = alloc_last_q;
      pop           = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty && head == '0) pop = 1'b1;
            else if (!empty) begin
               state_d   = S_RD_REQ;
               rd_en_d   = 1'b1;
               rd_addr_d = PAGE_ADDR_W'(head);
            end
         end
         S_RD_REQ: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            shift_d       = regfile_rd_data[shift_msb(SHIFT_W):shift_lsb(SHIFT_W)];
            delta_d       = regfile_rd_data[delta_msb(SHIFT_W):DELTA_LSB];
            gtr_d         = regfile_rd_data[GTR_BIT];
            seq_d         = 1'b0;
            state_d       = S_ISSUE;
            alloc_valid_d = 1'b1;
            alloc_seq_d   = 1'b0;
            alloc_shift_d = regfile_rd_data[shift_msb(SHIFT_W):shift_lsb(SHIFT_W)];
            alloc_last_d  = !regfile_rd_data[GTR_BIT];
         end
         S_ISSUE: begin
            if (alloc_ready) begin
               state_d       = S_GAP;
               gap_d         = GW'(BS_LAT - 1);
               alloc_valid_d = 1'b0;
               alloc_shift_d = '0;
               alloc_seq_d   = 1'b0;
               alloc_last_d  = 1'b0;
            end
         end
         S_GAP: begin
            if (gap_q != '0) gap_d = gap_q - GW'(1);
            else if (!seq_q && gtr_q) begin
               state_d       = S_ISSUE;
               seq_d         = 1'b1;
               alloc_valid_d = 1'b1;
               alloc_seq_d   = 1'b1;
               alloc_shift_d = seq1_shift;
               alloc_last_d  = 1'b1;
            end else begin
               // chain into the next read only when that entry is already stored
               pop = 1'b1;
               if (two_plus && head_nxt != '0) begin
                  state_d   = S_RD_REQ;
                  rd_en_d   = 1'b1;
                  rd_addr_d = PAGE_ADDR_W'(head_nxt);
               end else state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         gap_q         <= '0;
         shift_q       <= '0;
         delta_q       <= '0;
         gtr_q         <= 1'b0;
         seq_q         <= 1'b0;
         run_q         <= 1'b0;
         rd_en_q       <= 1'b0;
         rd_addr_q     <= '0;
         alloc_valid_q <= 1'b0;
         alloc_shift_q <= '0;
         alloc_seq_q   <= 1'b0;
         alloc_last_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         gap_q         <= gap_d;
         shift_q       <= shift_d;
         delta_q       <= delta_d;
         gtr_q         <= gtr_d;
         seq_q         <= seq_d;
         run_q         <= 1'b1;
         rd_en_q       <= rd_en_d;
         rd_addr_q     <= rd_addr_d;
         alloc_valid_q <= alloc_valid_d;
         alloc_shift_q <= alloc_shift_d;
         alloc_seq_q   <= alloc_seq_d;
         alloc_last_q  <= alloc_last_d;
      end
   end
`ifdef MEMSHARE_SCHED_PERF_CNT_EN
   logic [15:0] cnt_q, cnt_d;
   always_comb cnt_d = (alloc_valid_q && alloc_ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign alloc_cnt = cnt_q;
`else
   assign alloc_cnt = '0;
`endif
endmodule

// File: tb/tb_memshare_alloc_sched.sv
// tb_memshare_alloc_sched: directed bench for memshare_alloc_sched with a registered
// regFile model and a handshake monitor.
module tb_memshare_alloc_sched;
   logic       sys_clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rqst_valid = 1'b0;
   logic [4:0] rqst_pattern = '0;
   logic       rqst_ready;
   logic       regfile_rd_en;
   logic [4:0] regfile_rd_addr;
   logic [6:0] regfile_rd_data = '0;
   logic       alloc_valid;
   logic       alloc_ready = 1'b0;
   logic [2:0] alloc_shift;
   logic       alloc_seq_idx;
   logic       alloc_last;
   logic       sched_idle;
   logic [15:0] alloc_cnt;
   logic [6:0] rf [32];
   int         rd_cnt = 0;
   logic [4:0] last_addr = '0;
   logic [4:0] hs_q [$];
   int         total = 0;
   int         bad = 0;
   int         rd_base, hs_base, seen;

   memshare_alloc_sched dut (
      .sys_clk        (sys_clk),
      .rstn           (rstn),
      .rqst_valid     (rqst_valid),
      .rqst_pattern   (rqst_pattern),
      .rqst_ready     (rqst_ready),
      .regfile_rd_en  (regfile_rd_en),
      .regfile_rd_addr(regfile_rd_addr),
      .regfile_rd_data(regfile_rd_data),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_shift    (alloc_shift),
      .alloc_seq_idx  (alloc_seq_idx),
      .alloc_last     (alloc_last),
      .sched_idle     (sched_idle),
      .alloc_cnt      (alloc_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (regfile_rd_en) begin
         regfile_rd_data <= rf[regfile_rd_addr];
         rd_cnt <= rd_cnt + 1;
         last_addr <= regfile_rd_addr;
      end
      if (alloc_valid && alloc_ready) hs_q.push_back({alloc_seq_idx, alloc_last, alloc_shift});
   end

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!alloc_valid && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_valid_wait"}, 32'(alloc_valid), 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!sched_idle && n < 80) begin
         tick();
         n++;
      end
      chk({tag, "_idle_wait"}, 32'(sched_idle), 1);
   endtask

   task automatic push1(input logic [4:0] p);
      rqst_valid = 1'b1;
      rqst_pattern = p;
      tick();
      rqst_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[21] = {3'd2, 3'd1, 1'b1};
      rf[3]  = {3'd4, 3'd3, 1'b1};
      rf[1]  = {3'd1, 3'd0, 1'b0};
      rf[2]  = {3'd2, 3'd0, 1'b0};
      rf[4]  = {3'd3, 3'd0, 1'b0};
      rf[8]  = {3'd4, 3'd0, 1'b0};
      rf[16] = {3'd5, 3'd0, 1'b0};
      tick();
      tick();
      chk("rst_ready", 32'(rqst_ready), 0);
      chk("rst_valid", 32'(alloc_valid), 0);
      chk("rst_rd_en", 32'(regfile_rd_en), 0);
      chk("rst_idle", 32'(sched_idle), 0);
      chk("rst_cnt", 32'(alloc_cnt), 0);
      rstn = 1'b1;
      tick();
      chk("rel_ready", 32'(rqst_ready), 1);
      chk("rel_idle", 32'(sched_idle), 1);

      // two-sequence pattern with exact cycle timing
      alloc_ready = 1'b1;
      rd_base = rd_cnt;
      push1(5'b10101);
      chk("p1_n0_rd_en", 32'(regfile_rd_en), 0);
      chk("p1_n0_idle", 32'(sched_idle), 0);
      tick();
      chk("p1_n1_rd_en", 32'(regfile_rd_en), 1);
      chk("p1_n1_addr", 32'(regfile_rd_addr), 21);
      tick();
      chk("p1_n2_rd_en", 32'(regfile_rd_en), 0);
      chk("p1_n2_valid", 32'(alloc_valid), 0);
      tick();
      chk("p1_n3_valid", 32'(alloc_valid), 1);
      chk("p1_n3_shift", 32'(alloc_shift), 2);
      chk("p1_n3_seq", 32'(alloc_seq_idx), 0);
      chk("p1_n3_last", 32'(alloc_last), 0);
      tick();
      chk("p1_n4_valid", 32'(alloc_valid), 0);
      chk("p1_n4_shift", 32'(alloc_shift), 0);
      tick();
      tick();
      chk("p1_n6_valid", 32'(alloc_valid), 0);
      tick();
      chk("p1_n7_valid", 32'(alloc_valid), 1);
      chk("p1_n7_shift", 32'(alloc_shift), 3);
      chk("p1_n7_seq", 32'(alloc_seq_idx), 1);
      chk("p1_n7_last", 32'(alloc_last), 1);
      tick();
      chk("p1_n8_valid", 32'(alloc_valid), 0);
      tick();
      tick();
      tick();
      chk("p1_n11_idle", 32'(sched_idle), 1);
      chk("p1_reads", 32'(rd_cnt - rd_base), 1);

      // seq-1 shift wraps modulo the group size; outputs hold while stalled
      alloc_ready = 1'b0;
      push1(5'b00011);
      wait_valid("p2a");
      chk("p2a_shift", 32'(alloc_shift), 4);
      chk("p2a_last", 32'(alloc_last), 0);
      tick();
      tick();
      chk("p2a_hold_valid", 32'(alloc_valid), 1);
      chk("p2a_hold_shift", 32'(alloc_shift), 4);
      alloc_ready = 1'b1;
      tick();
      alloc_ready = 1'b0;
      wait_valid("p2b");
      chk("p2b_shift", 32'(alloc_shift), 2);
      chk("p2b_seq", 32'(alloc_seq_idx), 1);
      chk("p2b_last", 32'(alloc_last), 1);
      alloc_ready = 1'b1;
      tick();
      wait_idle("p2");

      // fill the FIFO while stalled; the fifth push must be refused
      alloc_ready = 1'b0;
      hs_base = hs_q.size();
      push1(5'b00001);
      push1(5'b00010);
      push1(5'b00100);
      chk("p3_ready_3", 32'(rqst_ready), 1);
      push1(5'b01000);
      chk("p3_ready_4", 32'(rqst_ready), 0);
      push1(5'b10000);
      chk("p3_ready_5", 32'(rqst_ready), 0);
      alloc_ready = 1'b1;
      wait_idle("p3");
      chk("p3_hs_count", 32'(hs_q.size() - hs_base), 4);
      for (int i = 0; i < 4; i++)
         if (hs_base + i < hs_q.size())
            chk($sformatf("p3_hs%0d", i), 32'(hs_q[hs_base + i]), 32'({1'b0, 1'b1, 3'(i + 1)}));

      // zero pattern is dropped without a read
      rd_base = rd_cnt;
      hs_base = hs_q.size();
      rqst_valid = 1'b1;
      rqst_pattern = 5'b00000;
      tick();
      rqst_pattern = 5'b00001;
      tick();
      rqst_valid = 1'b0;
      wait_idle("p4");
      chk("p4_reads", 32'(rd_cnt - rd_base), 1);
      chk("p4_addr", 32'(last_addr), 1);
      chk("p4_hs_count", 32'(hs_q.size() - hs_base), 1);

      // reset in the middle of GAP
      push1(5'b00010);
      wait_valid("p5");
      tick();
      tick();
      rstn = 1'b0;
      #1;
      chk("p5_rst_valid", 32'(alloc_valid), 0);
      chk("p5_rst_rd_en", 32'(regfile_rd_en), 0);
      chk("p5_rst_shift", 32'(alloc_shift), 0);
      chk("p5_rst_ready", 32'(rqst_ready), 0);
      tick();
      rstn = 1'b1;
      tick();
      chk("p5_rel_idle", 32'(sched_idle), 1);
      chk("p5_rel_ready", 32'(rqst_ready), 1);
      chk("p5_rel_cnt", 32'(alloc_cnt), 0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (alloc_valid) seen++;
      end
      chk("p5_no_valid", 32'(seen), 0);

      // handshake counter
      hs_base = hs_q.size();
      push1(5'b00001);
      push1(5'b00001);
      push1(5'b00001);
      wait_idle("p6");
      chk("p6_hs_count", 32'(hs_q.size() - hs_base), 3);
`ifdef MEMSHARE_SCHED_PERF_CNT_EN
      chk("p6_alloc_cnt", 32'(alloc_cnt), 3);
`else
      chk("p6_alloc_cnt", 32'(alloc_cnt), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
